// File: rtl/sample_stream_pkg.sv
// Shared types and helpers for the patterned byte-stream source.
package sample_stream_pkg;

    typedef enum logic [1:0] {
        INCR  = 2'd0,
        LFSR  = 2'd1,
        CONST = 2'd2,
        DECR  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam int GAP_WIDTH   = 4;
    localparam int COUNT_WIDTH = 32;

    // One Galois LFSR step on a zero-extended value; callers truncate to their width.
    function automatic logic [31:0] lfsr_step(input logic [31:0] d, input logic [31:0] taps);
        return (d >> 1) ^ (d[0] ? taps : 32'd0);
    endfunction

endpackage

// File: rtl/sample_stream_pattern.sv
// Burst payload generator: loads the seed on command accept and steps the
// value according to the latched mode on each advance strobe.
module sample_stream_pattern
    import sample_stream_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] LFSR_TAPS  = 8'hB8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] seed,
    input  mode_e                 mode,
    input  logic                  advance,
    output logic [DATA_WIDTH-1:0] data
);

    mode_e                 mode_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_next;

    always_comb begin
        data_next = data_q;
        case (mode_q)
            INCR:    data_next = data_q + DATA_WIDTH'(1);
            DECR:    data_next = data_q - DATA_WIDTH'(1);
            LFSR:    data_next = DATA_WIDTH'(lfsr_step(32'(data_q), 32'(LFSR_TAPS)));
            default: data_next = data_q;
        endcase
    end

    // An all-zero LFSR state would lock up, so a zero seed starts at 1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= '0;
            mode_q <= INCR;
        end else if (load) begin
            mode_q <= mode;
            data_q <= (mode == LFSR && seed == '0) ? DATA_WIDTH'(1) : seed;
        end else if (advance) begin
            data_q <= data_next;
        end
    end

    assign data = data_q;

endmodule

// File: rtl/sample_stream_source.sv
// Command-driven valid/ready byte-stream transmitter with patterned bursts,
// programmable inter-beat gap, backpressure handling and abort.
module sample_stream_source
    import sample_stream_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    LEN_WIDTH  = 16,
    parameter logic [DATA_WIDTH-1:0] LFSR_TAPS  = 8'hB8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [LEN_WIDTH-1:0]   cmd_len,
    input  logic [1:0]             cmd_mode,
    input  logic [DATA_WIDTH-1:0]  cmd_seed,
    input  logic [GAP_WIDTH-1:0]   cmd_gap,
    input  logic                   abort,
    output logic                   stream_out_valid,
    input  logic                   stream_out_ready,
    output logic [DATA_WIDTH-1:0]  stream_out_data,
    output logic                   stream_out_last,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] beat_count
);

    state_e                 state;
    logic [LEN_WIDTH-1:0]   beats_left;
    logic [GAP_WIDTH-1:0]   gap_cfg;
    logic [GAP_WIDTH-1:0]   gap_cnt;
    logic                   accept;
    logic                   load;
    logic                   handshake;
    logic                   advance;

    assign cmd_ready = (state == IDLE) & ~abort;
    assign accept    = cmd_valid & cmd_ready;
    assign load      = accept & (cmd_len != '0);
    assign handshake = stream_out_valid & stream_out_ready;
    assign advance   = handshake & ~stream_out_last & ~abort;
    assign busy      = (state != IDLE);

    sample_stream_pattern #(
        .DATA_WIDTH (DATA_WIDTH),
        .LFSR_TAPS  (LFSR_TAPS)
    ) u_pattern (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load),
        .seed    (cmd_seed),
        .mode    (mode_e'(cmd_mode)),
        .advance (advance),
        .data    (stream_out_data)
    );

    // beats_left counts the beat on the bus plus those still to come.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            stream_out_valid <= 1'b0;
            stream_out_last  <= 1'b0;
            beats_left       <= '0;
            gap_cfg          <= '0;
            gap_cnt          <= '0;
            beat_count       <= '0;
        end else begin
            if (handshake)
                beat_count <= beat_count + COUNT_WIDTH'(1);

            if (abort) begin
                state            <= IDLE;
                stream_out_valid <= 1'b0;
                stream_out_last  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (load) begin
                            state            <= SEND;
                            stream_out_valid <= 1'b1;
                            stream_out_last  <= (cmd_len == LEN_WIDTH'(1));
                            beats_left       <= cmd_len;
                            gap_cfg          <= cmd_gap;
                        end
                    end
                    SEND: begin
                        if (stream_out_ready) begin
                            if (stream_out_last) begin
                                state            <= IDLE;
                                stream_out_valid <= 1'b0;
                                stream_out_last  <= 1'b0;
                            end else begin
                                beats_left <= beats_left - LEN_WIDTH'(1);
                                if (gap_cfg != '0) begin
                                    state            <= GAP;
                                    stream_out_valid <= 1'b0;
                                    stream_out_last  <= 1'b0;
                                    gap_cnt          <= gap_cfg - GAP_WIDTH'(1);
                                end else begin
                                    stream_out_last <= (beats_left == LEN_WIDTH'(2));
                                end
                            end
                        end
                    end
                    GAP: begin
                        if (gap_cnt == '0) begin
                            state            <= SEND;
                            stream_out_valid <= 1'b1;
                            stream_out_last  <= (beats_left == LEN_WIDTH'(1));
                        end else begin
                            gap_cnt <= gap_cnt - GAP_WIDTH'(1);
                        end
                    end
                    default: begin
                        state            <= IDLE;
                        stream_out_valid <= 1'b0;
                        stream_out_last  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sample_stream_source.sv
// Directed checks of the stream source: patterns, backpressure, gaps, abort, reset.
module tb_sample_stream_source;

    logic        clk;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_len;
    logic [1:0]  cmd_mode;
    logic [7:0]  cmd_seed;
    logic [3:0]  cmd_gap;
    logic        abort;
    logic        stream_out_valid;
    logic        stream_out_ready;
    logic [7:0]  stream_out_data;
    logic        stream_out_last;
    logic        busy;
    logic [31:0] beat_count;

    int compared = 0;
    int mismatched = 0;

    sample_stream_source #(
        .DATA_WIDTH (8),
        .LEN_WIDTH  (16),
        .LFSR_TAPS  (8'hB8)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_len          (cmd_len),
        .cmd_mode         (cmd_mode),
        .cmd_seed         (cmd_seed),
        .cmd_gap          (cmd_gap),
        .abort            (abort),
        .stream_out_valid (stream_out_valid),
        .stream_out_ready (stream_out_ready),
        .stream_out_data  (stream_out_data),
        .stream_out_last  (stream_out_last),
        .busy             (busy),
        .beat_count       (beat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [15:0] len, input logic [1:0] mode,
                            input logic [7:0] seed, input logic [3:0] gap);
        cmd_valid = 1'b1;
        cmd_len   = len;
        cmd_mode  = mode;
        cmd_seed  = seed;
        cmd_gap   = gap;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cmd_valid = 1'b0; cmd_len = '0; cmd_mode = '0; cmd_seed = '0; cmd_gap = '0;
        abort = 1'b0; stream_out_ready = 1'b1;
        tick(); tick();
        reset_n = 1'b1;
        tick();
        compared++;
        if ({stream_out_valid, stream_out_last, busy} !== 3'b000) begin
            mismatched++;
            $display("FAIL reset_ctrl: got v/l/b=%b required 000", {stream_out_valid, stream_out_last, busy});
        end
        compared++;
        if (stream_out_data !== 8'h00) begin
            mismatched++;
            $display("FAIL reset_data: got %h required 00", stream_out_data);
        end
        compared++;
        if (beat_count !== 32'd0) begin
            mismatched++;
            $display("FAIL reset_count: got %0d required 0", beat_count);
        end
        compared++;
        if (cmd_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_cmd_ready: got %b required 1", cmd_ready);
        end
    endtask

    task automatic test_incr_wrap();
        logic [7:0] exp_data [4];
        exp_data = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        stream_out_ready = 1'b1;
        send_cmd(16'd4, 2'd0, 8'hFE, 4'd0);
        for (int i = 0; i < 4; i++) begin
            compared++;
            if ({stream_out_valid, stream_out_last, stream_out_data} !== {1'b1, (i == 3), exp_data[i]}) begin
                mismatched++;
                $display("FAIL incr_beat%0d: got v=%b l=%b d=%h required v=1 l=%b d=%h",
                         i, stream_out_valid, stream_out_last, stream_out_data, (i == 3), exp_data[i]);
            end
            tick();
        end
        compared++;
        if ({stream_out_valid, busy} !== 2'b00) begin
            mismatched++;
            $display("FAIL incr_end: got v/busy=%b required 00", {stream_out_valid, busy});
        end
        compared++;
        if (beat_count !== 32'd4) begin
            mismatched++;
            $display("FAIL incr_count: got %0d required 4", beat_count);
        end
    endtask

    task automatic test_backpressure();
        stream_out_ready = 1'b1;
        send_cmd(16'd3, 2'd2, 8'h5A, 4'd0);
        compared++;
        if ({stream_out_valid, stream_out_last, stream_out_data} !== {2'b10, 8'h5A}) begin
            mismatched++;
            $display("FAIL bp_beat1: got v=%b l=%b d=%h required v=1 l=0 d=5a",
                     stream_out_valid, stream_out_last, stream_out_data);
        end
        tick();
        stream_out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            compared++;
            if ({stream_out_valid, stream_out_last, stream_out_data} !== {2'b10, 8'h5A}) begin
                mismatched++;
                $display("FAIL bp_hold%0d: got v=%b l=%b d=%h required v=1 l=0 d=5a",
                         i, stream_out_valid, stream_out_last, stream_out_data);
            end
        end
        compared++;
        if (beat_count !== 32'd5) begin
            mismatched++;
            $display("FAIL bp_count_stalled: got %0d required 5", beat_count);
        end
        stream_out_ready = 1'b1;
        tick();
        compared++;
        if ({stream_out_valid, stream_out_last, stream_out_data} !== {2'b11, 8'h5A}) begin
            mismatched++;
            $display("FAIL bp_beat3: got v=%b l=%b d=%h required v=1 l=1 d=5a",
                     stream_out_valid, stream_out_last, stream_out_data);
        end
        tick();
        compared++;
        if ({stream_out_valid, beat_count} !== {1'b0, 32'd7}) begin
            mismatched++;
            $display("FAIL bp_end: got v=%b count=%0d required v=0 count=7", stream_out_valid, beat_count);
        end
    endtask

    task automatic test_lfsr_gap();
        logic [7:0] exp_data [3];
        exp_data = '{8'h01, 8'hB8, 8'h5C};
        stream_out_ready = 1'b1;
        send_cmd(16'd3, 2'd1, 8'h00, 4'd2);
        for (int b = 0; b < 3; b++) begin
            compared++;
            if ({stream_out_valid, stream_out_last, stream_out_data} !== {1'b1, (b == 2), exp_data[b]}) begin
                mismatched++;
                $display("FAIL lfsr_beat%0d: got v=%b l=%b d=%h required v=1 l=%b d=%h",
                         b, stream_out_valid, stream_out_last, stream_out_data, (b == 2), exp_data[b]);
            end
            tick();
            if (b < 2) begin
                for (int g = 0; g < 2; g++) begin
                    compared++;
                    if ({stream_out_valid, stream_out_last} !== 2'b00) begin
                        mismatched++;
                        $display("FAIL lfsr_gap%0d_%0d: got v/l=%b required 00", b, g, {stream_out_valid, stream_out_last});
                    end
                    tick();
                end
            end
        end
        compared++;
        if ({stream_out_valid, busy, beat_count} !== {2'b00, 32'd10}) begin
            mismatched++;
            $display("FAIL lfsr_end: got v=%b busy=%b count=%0d required 0 0 10", stream_out_valid, busy, beat_count);
        end
    endtask

    task automatic test_zero_len();
        cmd_valid = 1'b1; cmd_len = 16'd0; cmd_mode = 2'd0; cmd_seed = 8'h33; cmd_gap = 4'd0;
        #1;
        compared++;
        if (cmd_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL zero_cmd_ready: got %b required 1", cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            compared++;
            if ({stream_out_valid, busy, beat_count} !== {2'b00, 32'd10}) begin
                mismatched++;
                $display("FAIL zero_idle%0d: got v=%b busy=%b count=%0d required 0 0 10",
                         i, stream_out_valid, busy, beat_count);
            end
            tick();
        end
    endtask

    task automatic test_abort();
        stream_out_ready = 1'b1;
        send_cmd(16'd100, 2'd0, 8'h00, 4'd0);
        for (int i = 0; i < 10; i++) tick();
        compared++;
        if ({stream_out_valid, stream_out_data, beat_count} !== {1'b1, 8'h0A, 32'd20}) begin
            mismatched++;
            $display("FAIL abort_pre: got v=%b d=%h count=%0d required 1 0a 20",
                     stream_out_valid, stream_out_data, beat_count);
        end
        stream_out_ready = 1'b0;
        abort = 1'b1;
        #1;
        compared++;
        if (cmd_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL abort_cmd_ready_held: got %b required 0", cmd_ready);
        end
        tick();
        compared++;
        if ({stream_out_valid, stream_out_last, busy, beat_count} !== {3'b000, 32'd20}) begin
            mismatched++;
            $display("FAIL abort_after: got v=%b l=%b busy=%b count=%0d required 0 0 0 20",
                     stream_out_valid, stream_out_last, busy, beat_count);
        end
        abort = 1'b0;
        #1;
        compared++;
        if (cmd_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL abort_cmd_ready_back: got %b required 1", cmd_ready);
        end
        stream_out_ready = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_data [3];
        exp_data = '{8'h01, 8'h00, 8'hFF};
        stream_out_ready = 1'b1;
        send_cmd(16'd3, 2'd3, 8'h01, 4'd0);
        for (int i = 0; i < 3; i++) begin
            compared++;
            if ({stream_out_valid, stream_out_last, stream_out_data} !== {1'b1, (i == 2), exp_data[i]}) begin
                mismatched++;
                $display("FAIL decr_beat%0d: got v=%b l=%b d=%h required v=1 l=%b d=%h",
                         i, stream_out_valid, stream_out_last, stream_out_data, (i == 2), exp_data[i]);
            end
            tick();
        end
        compared++;
        if ({stream_out_valid, cmd_ready, beat_count} !== {2'b01, 32'd23}) begin
            mismatched++;
            $display("FAIL decr_end: got v=%b cmd_ready=%b count=%0d required 0 1 23",
                     stream_out_valid, cmd_ready, beat_count);
        end
    endtask

    task automatic test_reset_mid_burst();
        stream_out_ready = 1'b1;
        send_cmd(16'd5, 2'd0, 8'h30, 4'd0);
        tick(); tick();
        #2;
        reset_n = 1'b0;
        #1;
        compared++;
        if ({stream_out_valid, stream_out_last, busy, stream_out_data, beat_count} !== {3'b000, 8'h00, 32'd0}) begin
            mismatched++;
            $display("FAIL rst_async: got v=%b l=%b busy=%b d=%h count=%0d required all zero",
                     stream_out_valid, stream_out_last, busy, stream_out_data, beat_count);
        end
        tick();
        reset_n = 1'b1;
        tick();
        send_cmd(16'd2, 2'd2, 8'h77, 4'd0);
        compared++;
        if ({stream_out_valid, stream_out_last, stream_out_data} !== {2'b10, 8'h77}) begin
            mismatched++;
            $display("FAIL rst_new_first: got v=%b l=%b d=%h required v=1 l=0 d=77",
                     stream_out_valid, stream_out_last, stream_out_data);
        end
        tick();
        compared++;
        if ({stream_out_valid, stream_out_last, stream_out_data} !== {2'b11, 8'h77}) begin
            mismatched++;
            $display("FAIL rst_new_last: got v=%b l=%b d=%h required v=1 l=1 d=77",
                     stream_out_valid, stream_out_last, stream_out_data);
        end
        tick();
        compared++;
        if ({stream_out_valid, beat_count} !== {1'b0, 32'd2}) begin
            mismatched++;
            $display("FAIL rst_new_count: got v=%b count=%0d required 0 2", stream_out_valid, beat_count);
        end
    endtask

    initial begin
        test_reset();
        test_incr_wrap();
        test_backpressure();
        test_lfsr_gap();
        test_zero_len();
        test_abort();
        test_back_to_back();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
